// File: rtl/ni_csr_irq_bank.sv
// Network-interface CSR bank with per-VC interrupt detection and coalescing.
// Decodes single-cycle CSR accesses into registered responses and tracks
// buffer conditions per virtual channel. It raises sticky status bits and
// counts rise events per VC. A coalesced interrupt line fires once the
// pending time reaches the programmed threshold.
module ni_csr_irq_bank #(
   parameter int          NUM_VC      = 3,
   parameter int          OCUP_W      = 16,
   parameter int          TIMER_W     = 16,
   parameter logic [31:0] ROUTER_X_ID = 32'd0,
   parameter logic [31:0] ROUTER_Y_ID = 32'd0,
   parameter logic [31:0] VERSION     = 32'h0001_0002
) (
   input  logic                     clk_axi,
   input  logic                     arst_axi,
   input  logic                     req_valid,
   input  logic                     req_wr,
   input  logic [7:0]               req_addr,
   input  logic [31:0]              req_wdata,
   output logic                     resp_valid,
   output logic [31:0]              resp_data,
   output logic                     resp_error,
   input  logic [NUM_VC-1:0]        empty_i,
   input  logic [NUM_VC-1:0]        full_i,
   input  logic [NUM_VC*OCUP_W-1:0] ocup_i,
   output logic [NUM_VC-1:0]        irq_vcs_o,
   output logic                     irq_trig_o
);

   // Architectural state
   logic [NUM_VC-1:0]   status_q, status_d;
   logic [NUM_VC-1:0]   mask_q, mask_d;
   logic [2*NUM_VC-1:0] mode_q, mode_d;
   logic [OCUP_W-1:0]   thresh_q, thresh_d;
   logic [TIMER_W-1:0]  coalesce_q, coalesce_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic [NUM_VC-1:0]   cond_q;
   logic [15:0]         evtcnt_q [NUM_VC];
   logic [15:0]         evtcnt_d [NUM_VC];
   logic                irq_trig_q, irq_trig_d;
   logic                resp_valid_q, resp_error_q, resp_error_d;
   logic [31:0]         resp_data_q, resp_data_d;

   // Decode and condition signals
   logic [5:0]          word_s;
   logic [2:0]          evt_idx_s;
   logic                is_evt_s, err_s, wr_ok_s, rd_ok_s;
   logic [31:0]         rdata_s;
   logic [NUM_VC-1:0]   cond_s, rise_s, status_clr_s;

   assign irq_vcs_o  = status_q & mask_q;
   assign irq_trig_o = irq_trig_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_error = resp_error_q;

   // Address decode: classify the access and flag errors before any state update
   always_comb begin
      word_s    = req_addr[7:2];
      is_evt_s  = (word_s >= 6'd8) && (word_s < 6'(8 + NUM_VC));
      evt_idx_s = 3'(word_s - 6'd8);
      err_s     = (req_addr[1:0] != 2'd0)
                  || !((word_s <= 6'd7) || is_evt_s)
                  || (req_wr && ((word_s <= 6'd2) || is_evt_s));
      wr_ok_s   = req_valid && !err_s && req_wr;
      rd_ok_s   = req_valid && !err_s && !req_wr;
   end

   // Read-data mux; unused upper bits of narrow registers read as zero
   always_comb begin
      rdata_s = 32'd0;
      case (word_s)
         6'd0:    rdata_s = VERSION;
         6'd1:    rdata_s = ROUTER_X_ID;
         6'd2:    rdata_s = ROUTER_Y_ID;
         6'd3:    rdata_s[NUM_VC-1:0] = status_q;
         6'd4:    rdata_s[NUM_VC-1:0] = mask_q;
         6'd5:    rdata_s[2*NUM_VC-1:0] = mode_q;
         6'd6:    rdata_s[OCUP_W-1:0] = thresh_q;
         6'd7:    rdata_s[TIMER_W-1:0] = coalesce_q;
         default: begin
            if (is_evt_s) begin
               rdata_s[15:0] = evtcnt_q[evt_idx_s];
            end else begin
               rdata_s = 32'd0;
            end
         end
      endcase
      resp_data_d  = rd_ok_s ? rdata_s : 32'd0;
      resp_error_d = req_valid && err_s;
   end

   // Per-VC interrupt condition selected by the VC's mode field
   always_comb begin
      cond_s = {NUM_VC{1'b0}};
      for (int i = 0; i < NUM_VC; i++) begin
         case (mode_q[2*i +: 2])
            2'd0:    cond_s[i] = ~empty_i[i];
            2'd1:    cond_s[i] = full_i[i];
            2'd2:    cond_s[i] = (ocup_i[i*OCUP_W +: OCUP_W] >= thresh_q);
            default: cond_s[i] = 1'b0;
         endcase
      end
      rise_s = cond_s & ~cond_q;
   end

   // Register next-state: CSR writes, sticky status, event counters, coalescing
   always_comb begin
      status_clr_s = (wr_ok_s && (word_s == 6'd3)) ? req_wdata[NUM_VC-1:0] : {NUM_VC{1'b0}};
      // A rise in the same cycle as a clear wins, so no event is lost
      status_d     = (status_q & ~status_clr_s) | rise_s;
      mask_d       = (wr_ok_s && (word_s == 6'd4)) ? req_wdata[NUM_VC-1:0] : mask_q;
      mode_d       = (wr_ok_s && (word_s == 6'd5)) ? req_wdata[2*NUM_VC-1:0] : mode_q;
      thresh_d     = (wr_ok_s && (word_s == 6'd6)) ? req_wdata[OCUP_W-1:0] : thresh_q;
      coalesce_d   = (wr_ok_s && (word_s == 6'd7)) ? req_wdata[TIMER_W-1:0] : coalesce_q;
      for (int i = 0; i < NUM_VC; i++) begin
         if (rd_ok_s && is_evt_s && (evt_idx_s == 3'(i))) begin
            // Clear-on-read; a coincident rise is counted into the fresh value
            evtcnt_d[i] = rise_s[i] ? 16'd1 : 16'd0;
         end else if (rise_s[i] && (evtcnt_q[i] != 16'hFFFF)) begin
            evtcnt_d[i] = evtcnt_q[i] + 16'd1;
         end else begin
            evtcnt_d[i] = evtcnt_q[i];
         end
      end
      if (irq_vcs_o == {NUM_VC{1'b0}}) begin
         timer_d = {TIMER_W{1'b0}};
      end else if (timer_q != {TIMER_W{1'b1}}) begin
         timer_d = timer_q + {{(TIMER_W-1){1'b0}}, 1'b1};
      end else begin
         timer_d = timer_q;
      end
      irq_trig_d = (|irq_vcs_o) && (timer_q >= coalesce_q);
   end

   // State and response registers; reset forces every output low immediately
   always_ff @(posedge clk_axi or negedge arst_axi) begin
      if (!arst_axi) begin
         status_q     <= {NUM_VC{1'b0}};
         mask_q       <= {NUM_VC{1'b1}};
         mode_q       <= {(2*NUM_VC){1'b0}};
         thresh_q     <= {OCUP_W{1'b0}};
         coalesce_q   <= {TIMER_W{1'b0}};
         timer_q      <= {TIMER_W{1'b0}};
         cond_q       <= {NUM_VC{1'b0}};
         irq_trig_q   <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= 32'd0;
         resp_error_q <= 1'b0;
         for (int i = 0; i < NUM_VC; i++) begin
            evtcnt_q[i] <= 16'd0;
         end
      end else begin
         status_q     <= status_d;
         mask_q       <= mask_d;
         mode_q       <= mode_d;
         thresh_q     <= thresh_d;
         coalesce_q   <= coalesce_d;
         timer_q      <= timer_d;
         cond_q       <= cond_s;
         irq_trig_q   <= irq_trig_d;
         resp_valid_q <= req_valid;
         resp_data_q  <= resp_data_d;
         resp_error_q <= resp_error_d;
         for (int i = 0; i < NUM_VC; i++) begin
            evtcnt_q[i] <= evtcnt_d[i];
         end
      end
   end

endmodule
